wf_state_regfile: RTL and testbench
===================================

Name: wf_state_regfile

Overview:
- Parametrised per-wavefront special-state register file holding EXEC, VCC, M0 and SCC for NUM_WF wavefronts.
- Sits between fetch, the SALU, the vector ALUs (SIMD/SIMF), the LSU and issue.
- Generalises the fixed 40-entry, 8-port exec block:
  - configurable depth and VALU port count;
  - valid/ready round-robin arbitration of VALU VCC writes;
  - registered reads with write-through bypass;
  - registered write notifications to issue;
  - out-of-range wfid error detection.

Parameters:
NUM_WF, 40, number of wavefront entries
WFID_W, 6, wavefront id width; must satisfy 2^WFID_W >= NUM_WF
NUM_VALU, 8, number of vector ALU VCC write ports and ALU read requesters (SALU is read requester NUM_VALU)
MASK_W, 64, EXEC/VCC width (lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
init_en  in  1  fetch wavefront init
init_wfid  in  WFID_W  wavefront being initialised
init_exec  in  MASK_W  initial EXEC value
salu_wr_wfid  in  WFID_W  SALU write target
salu_wr_exec_en / salu_wr_vcc_en / salu_wr_m0_en / salu_wr_scc_en  in  1 each  SALU field write enables
salu_wr_exec / salu_wr_vcc  in  MASK_W each  SALU write data
salu_wr_m0  in  32  SALU M0 data
salu_wr_scc  in  1  SALU SCC data
valu_vcc_valid  in  NUM_VALU  per-port VCC write request
valu_vcc_wfid  in  NUM_VALU*WFID_W  packed; port i at [i*WFID_W +: WFID_W]
valu_vcc_data  in  NUM_VALU*MASK_W  packed per port
valu_vcc_ready  out  NUM_VALU  one-hot grant (combinational)
alu_rd_en  in  NUM_VALU+1  ALU read requests; bit NUM_VALU is the SALU
alu_rd_wfid  in  (NUM_VALU+1)*WFID_W  packed read ids
alu_rd_exec / alu_rd_vcc  out  MASK_W each  registered ALU read data
alu_rd_m0  out  32  registered ALU read data
alu_rd_scc  out  1  registered ALU read data
lsu_rd_wfid  in  WFID_W  LSU read id (reads every cycle)
lsu_rd_exec  out  MASK_W  registered
lsu_rd_m0  out  32  registered
issue_vcc_wr_en  out  1  registered: VCC committed last cycle (any source)
issue_vcc_wr_wfid  out  WFID_W  wfid of that commit
issue_exec_wr_en / issue_m0_wr_en / issue_scc_wr_en  out  1 each  registered SALU commit pulses
err_oor  out  1  sticky: any enabled access used wfid >= NUM_WF

Behaviour:
- Reset (async, rst=1):
  - all entries, all read outputs, all issue outputs and err_oor go to 0;
  - RR pointer goes to 0.
- Init write (init_en): entry init_wfid gets EXEC=init_exec, VCC=0, M0=0, SCC=0.
- Field write priority on the same wfid in the same cycle: init > SALU > VALU.
  - Lower-priority write to a different wfid proceeds.
  - Different fields of one entry may be written in the same cycle.
- VALU VCC arbitration:
  - At most one grant per cycle.
  - Grant goes to the first valid port searching ptr, ptr+1, … mod NUM_VALU.
  - Candidate is suppressed (ready=0, pointer unchanged, no fallback to another port that cycle) if:
    - init_en is active with init_wfid equal to its wfid; or
    - salu_wr_vcc_en is active with salu_wr_wfid equal to its wfid.
  - On grant: data is written at the clock edge; ptr <= granted+1 mod NUM_VALU.
  - Source holds valid, wfid and data until it sees ready=1. ready is never asserted without valid.
- ALU read mux:
  - Lowest-index asserted alu_rd_en selects the wfid.
  - If no bit is asserted, alu_rd_* hold their previous values.
- Read latency and bypass:
  - Read latency is 1 cycle: outputs register the entry contents at the edge.
  - If a write commits to the same wfid and field at that edge, the output shows the new (post-priority) value.
- issue_* outputs:
  - Asserted for exactly one cycle after each commit.
  - issue_vcc_wr_wfid follows the winning VCC source: init, SALU or the granted VALU.
  - If both SALU and VALU commit VCC in one cycle (different wfids), issue_vcc_wr_wfid reports the SALU wfid.
- Out-of-range wfid (>= NUM_WF) on an enabled write, VALU request or read:
  - the write is dropped;
  - an out-of-range VALU request is still granted, so it drains;
  - the read returns 0;
  - err_oor is set and stays set until reset.
- Reset mid-operation:
  - pending VALU requests are not committed;
  - they are granted from ptr=0 after reset releases.

Test Plan:
- Reset, init_en wfid=5 init_exec=64'hFFFF_0000_FFFF_0000, then alu_rd_en[0] wfid=5 -> next cycle alu_rd_exec=64'hFFFF_0000_FFFF_0000, vcc=0, m0=0, scc=0; lsu_rd_exec matches.
- valu_vcc_valid=8'hFF, distinct wfids 0..7, data=i -> grants port 0,1,…,7 one per cycle; each port drops valid on grant; VCC[i]=i; issue_vcc_wr_wfid sequence 0..7.
- SALU vcc wfid=3 data=A and VALU port 2 vcc wfid=3 data=B same cycle -> ready[2]=0, VCC[3]=A; following cycle ready[2]=1, VCC[3]=B.
- Read wfid=9 on the same edge as SALU writes m0=32'h1234 to wfid=9 -> alu_rd_m0=32'h1234 the next cycle (bypass).
- SALU writes exec to wfid=45 (NUM_WF=40) -> no entry changes, err_oor=1 and stays 1; alu read of wfid=45 returns 0.
- Assert rst during a 4-port VALU burst after 2 grants -> outputs and ptr are 0; after release, remaining requesters are granted starting from the lowest index.

Source files
------------

// File: rtl/wf_state_regfile.sv
// wf_state_regfile: per-wavefront EXEC/VCC/M0/SCC state, with round-robin arbitration of the VALU VCC write ports.
// Latency: reads and issue notifications are registered (1 cycle); a write committing at the same edge bypasses into the read outputs.
// Backpressure: at most one VALU VCC grant per cycle on a combinational ready; a port that collides with init or a SALU VCC write to its wfid waits.
module wf_state_regfile #(
  parameter int NUM_WF   = 40,
  parameter int WFID_W   = 6,
  parameter int NUM_VALU = 8,
  parameter int MASK_W   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init_en,
  input  logic [WFID_W-1:0]              init_wfid,
  input  logic [MASK_W-1:0]              init_exec,
  input  logic [WFID_W-1:0]              salu_wr_wfid,
  input  logic                           salu_wr_exec_en,
  input  logic                           salu_wr_vcc_en,
  input  logic                           salu_wr_m0_en,
  input  logic                           salu_wr_scc_en,
  input  logic [MASK_W-1:0]              salu_wr_exec,
  input  logic [MASK_W-1:0]              salu_wr_vcc,
  input  logic [31:0]                    salu_wr_m0,
  input  logic                           salu_wr_scc,
  input  logic [NUM_VALU-1:0]            valu_vcc_valid,
  input  logic [NUM_VALU*WFID_W-1:0]     valu_vcc_wfid,
  input  logic [NUM_VALU*MASK_W-1:0]     valu_vcc_data,
  output logic [NUM_VALU-1:0]            valu_vcc_ready,
  input  logic [NUM_VALU:0]              alu_rd_en,
  input  logic [(NUM_VALU+1)*WFID_W-1:0] alu_rd_wfid,
  output logic [MASK_W-1:0]              alu_rd_exec,
  output logic [MASK_W-1:0]              alu_rd_vcc,
  output logic [31:0]                    alu_rd_m0,
  output logic                           alu_rd_scc,
  input  logic [WFID_W-1:0]              lsu_rd_wfid,
  output logic [MASK_W-1:0]              lsu_rd_exec,
  output logic [31:0]                    lsu_rd_m0,
  output logic                           issue_vcc_wr_en,
  output logic [WFID_W-1:0]              issue_vcc_wr_wfid,
  output logic                           issue_exec_wr_en,
  output logic                           issue_m0_wr_en,
  output logic                           issue_scc_wr_en,
  output logic                           err_oor
);

  localparam int PTR_W = (NUM_VALU > 1) ? $clog2(NUM_VALU) : 1;

  logic [MASK_W-1:0] exec_q [NUM_WF];
  logic [MASK_W-1:0] vcc_q  [NUM_WF];
  logic [31:0]       m0_q   [NUM_WF];
  logic              scc_q  [NUM_WF];
  logic [MASK_W-1:0] exec_d [NUM_WF];
  logic [MASK_W-1:0] vcc_d  [NUM_WF];
  logic [31:0]       m0_d   [NUM_WF];
  logic              scc_d  [NUM_WF];

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W:0]    arb_sum;
  logic              cand_found;
  logic [PTR_W-1:0]  cand_idx;
  logic [WFID_W-1:0] cand_wfid;
  logic [MASK_W-1:0] cand_data;
  logic              suppress;
  logic              gnt_any;

  logic              init_ok, salu_blk, valu_we, valu_oor, oor_hit;
  logic              s_exec_we, s_vcc_we, s_m0_we, s_scc_we;
  logic              alu_sel_vld;
  logic [WFID_W-1:0] alu_sel_wfid;

  function automatic logic in_range(input logic [WFID_W-1:0] w);
    return 32'(w) < 32'(NUM_WF);
  endfunction

  // Round-robin search from ptr; the first valid port is the only candidate, and a wfid collision stalls it without fallback.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    arb_sum    = '0;
    for (int k = 0; k < NUM_VALU; k++) begin
      arb_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (arb_sum >= (PTR_W+1)'(NUM_VALU)) arb_sum = arb_sum - (PTR_W+1)'(NUM_VALU);
      if (!cand_found && valu_vcc_valid[arb_sum[PTR_W-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = arb_sum[PTR_W-1:0];
      end
    end
    cand_wfid = valu_vcc_wfid[int'(cand_idx)*WFID_W +: WFID_W];
    cand_data = valu_vcc_data[int'(cand_idx)*MASK_W +: MASK_W];
    suppress  = (init_en && (init_wfid == cand_wfid)) ||
                (salu_wr_vcc_en && (salu_wr_wfid == cand_wfid));
    // Hold off grants during reset so sources keep their requests pending.
    gnt_any   = cand_found && !suppress && !rst;
    valu_vcc_ready = '0;
    if (gnt_any) valu_vcc_ready[cand_idx] = 1'b1;
  end

  // ALU read mux: the lowest-index asserted requester picks the wfid.
  always_comb begin
    alu_sel_vld  = 1'b0;
    alu_sel_wfid = '0;
    for (int k = NUM_VALU; k >= 0; k--) begin
      if (alu_rd_en[k]) begin
        alu_sel_vld  = 1'b1;
        alu_sel_wfid = alu_rd_wfid[k*WFID_W +: WFID_W];
      end
    end
  end

  // Per-source commit qualifiers (range check and init-over-SALU priority) and out-of-range detection.
  always_comb begin
    init_ok   = init_en && in_range(init_wfid);
    salu_blk  = init_en && (init_wfid == salu_wr_wfid);
    s_exec_we = salu_wr_exec_en && in_range(salu_wr_wfid) && !salu_blk;
    s_vcc_we  = salu_wr_vcc_en  && in_range(salu_wr_wfid) && !salu_blk;
    s_m0_we   = salu_wr_m0_en   && in_range(salu_wr_wfid) && !salu_blk;
    s_scc_we  = salu_wr_scc_en  && in_range(salu_wr_wfid) && !salu_blk;
    valu_we   = gnt_any && in_range(cand_wfid);
    valu_oor  = 1'b0;
    for (int k = 0; k < NUM_VALU; k++) begin
      if (valu_vcc_valid[k] && !in_range(valu_vcc_wfid[k*WFID_W +: WFID_W])) valu_oor = 1'b1;
    end
    oor_hit = (init_en && !in_range(init_wfid)) ||
              ((salu_wr_exec_en || salu_wr_vcc_en || salu_wr_m0_en || salu_wr_scc_en) &&
               !in_range(salu_wr_wfid)) ||
              valu_oor ||
              (alu_sel_vld && !in_range(alu_sel_wfid)) ||
              !in_range(lsu_rd_wfid);
  end

  // Next-state image: lowest priority applied first so init overwrites SALU, which overwrites VALU.
  always_comb begin
    exec_d = exec_q;
    vcc_d  = vcc_q;
    m0_d   = m0_q;
    scc_d  = scc_q;
    if (valu_we)   vcc_d[cand_wfid]     = cand_data;
    if (s_exec_we) exec_d[salu_wr_wfid] = salu_wr_exec;
    if (s_vcc_we)  vcc_d[salu_wr_wfid]  = salu_wr_vcc;
    if (s_m0_we)   m0_d[salu_wr_wfid]   = salu_wr_m0;
    if (s_scc_we)  scc_d[salu_wr_wfid]  = salu_wr_scc;
    if (init_ok) begin
      exec_d[init_wfid] = init_exec;
      vcc_d[init_wfid]  = '0;
      m0_d[init_wfid]   = '0;
      scc_d[init_wfid]  = 1'b0;
    end
  end

  // Entry storage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        exec_q[i] <= '0;
        vcc_q[i]  <= '0;
        m0_q[i]   <= '0;
        scc_q[i]  <= 1'b0;
      end
      ptr <= '0;
    end else begin
      exec_q <= exec_d;
      vcc_q  <= vcc_d;
      m0_q   <= m0_d;
      scc_q  <= scc_d;
      if (gnt_any) ptr <= (cand_idx == PTR_W'(NUM_VALU-1)) ? '0 : cand_idx + PTR_W'(1);
    end
  end

  // Registered reads from the post-write image (bypass), issue notifications and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_rd_exec       <= '0;
      alu_rd_vcc        <= '0;
      alu_rd_m0         <= '0;
      alu_rd_scc        <= 1'b0;
      lsu_rd_exec       <= '0;
      lsu_rd_m0         <= '0;
      issue_vcc_wr_en   <= 1'b0;
      issue_vcc_wr_wfid <= '0;
      issue_exec_wr_en  <= 1'b0;
      issue_m0_wr_en    <= 1'b0;
      issue_scc_wr_en   <= 1'b0;
      err_oor           <= 1'b0;
    end else begin
      if (alu_sel_vld) begin
        if (in_range(alu_sel_wfid)) begin
          alu_rd_exec <= exec_d[alu_sel_wfid];
          alu_rd_vcc  <= vcc_d[alu_sel_wfid];
          alu_rd_m0   <= m0_d[alu_sel_wfid];
          alu_rd_scc  <= scc_d[alu_sel_wfid];
        end else begin
          alu_rd_exec <= '0;
          alu_rd_vcc  <= '0;
          alu_rd_m0   <= '0;
          alu_rd_scc  <= 1'b0;
        end
      end
      if (in_range(lsu_rd_wfid)) begin
        lsu_rd_exec <= exec_d[lsu_rd_wfid];
        lsu_rd_m0   <= m0_d[lsu_rd_wfid];
      end else begin
        lsu_rd_exec <= '0;
        lsu_rd_m0   <= '0;
      end
      issue_vcc_wr_en  <= init_ok || s_vcc_we || valu_we;
      if (init_ok)       issue_vcc_wr_wfid <= init_wfid;
      else if (s_vcc_we) issue_vcc_wr_wfid <= salu_wr_wfid;
      else if (valu_we)  issue_vcc_wr_wfid <= cand_wfid;
      issue_exec_wr_en <= s_exec_we;
      issue_m0_wr_en   <= s_m0_we;
      issue_scc_wr_en  <= s_scc_we;
      if (oor_hit) err_oor <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wf_state_regfile.sv
// Directed bench for wf_state_regfile: init/read, VALU round-robin, priority collisions, bypass, out-of-range and mid-burst reset.
module tb_wf_state_regfile;
  localparam int NUM_WF   = 40;
  localparam int WFID_W   = 6;
  localparam int NUM_VALU = 8;
  localparam int MASK_W   = 64;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           init_en;
  logic [WFID_W-1:0]              init_wfid;
  logic [MASK_W-1:0]              init_exec;
  logic [WFID_W-1:0]              salu_wr_wfid;
  logic                           salu_wr_exec_en, salu_wr_vcc_en, salu_wr_m0_en, salu_wr_scc_en;
  logic [MASK_W-1:0]              salu_wr_exec, salu_wr_vcc;
  logic [31:0]                    salu_wr_m0;
  logic                           salu_wr_scc;
  logic [NUM_VALU-1:0]            valu_vcc_valid;
  logic [NUM_VALU*WFID_W-1:0]     valu_vcc_wfid;
  logic [NUM_VALU*MASK_W-1:0]     valu_vcc_data;
  logic [NUM_VALU-1:0]            valu_vcc_ready;
  logic [NUM_VALU:0]              alu_rd_en;
  logic [(NUM_VALU+1)*WFID_W-1:0] alu_rd_wfid;
  logic [MASK_W-1:0]              alu_rd_exec, alu_rd_vcc;
  logic [31:0]                    alu_rd_m0;
  logic                           alu_rd_scc;
  logic [WFID_W-1:0]              lsu_rd_wfid;
  logic [MASK_W-1:0]              lsu_rd_exec;
  logic [31:0]                    lsu_rd_m0;
  logic                           issue_vcc_wr_en;
  logic [WFID_W-1:0]              issue_vcc_wr_wfid;
  logic                           issue_exec_wr_en, issue_m0_wr_en, issue_scc_wr_en;
  logic                           err_oor;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [63:0] VA   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VB   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] TAG  = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] IEX  = 64'hFFFF_0000_FFFF_0000;

  wf_state_regfile #(
    .NUM_WF(NUM_WF), .WFID_W(WFID_W), .NUM_VALU(NUM_VALU), .MASK_W(MASK_W)
  ) dut (
    .clk(clk), .rst(rst),
    .init_en(init_en), .init_wfid(init_wfid), .init_exec(init_exec),
    .salu_wr_wfid(salu_wr_wfid),
    .salu_wr_exec_en(salu_wr_exec_en), .salu_wr_vcc_en(salu_wr_vcc_en),
    .salu_wr_m0_en(salu_wr_m0_en), .salu_wr_scc_en(salu_wr_scc_en),
    .salu_wr_exec(salu_wr_exec), .salu_wr_vcc(salu_wr_vcc),
    .salu_wr_m0(salu_wr_m0), .salu_wr_scc(salu_wr_scc),
    .valu_vcc_valid(valu_vcc_valid), .valu_vcc_wfid(valu_vcc_wfid),
    .valu_vcc_data(valu_vcc_data), .valu_vcc_ready(valu_vcc_ready),
    .alu_rd_en(alu_rd_en), .alu_rd_wfid(alu_rd_wfid),
    .alu_rd_exec(alu_rd_exec), .alu_rd_vcc(alu_rd_vcc),
    .alu_rd_m0(alu_rd_m0), .alu_rd_scc(alu_rd_scc),
    .lsu_rd_wfid(lsu_rd_wfid), .lsu_rd_exec(lsu_rd_exec), .lsu_rd_m0(lsu_rd_m0),
    .issue_vcc_wr_en(issue_vcc_wr_en), .issue_vcc_wr_wfid(issue_vcc_wr_wfid),
    .issue_exec_wr_en(issue_exec_wr_en), .issue_m0_wr_en(issue_m0_wr_en),
    .issue_scc_wr_en(issue_scc_wr_en), .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    init_en = 1'b0; init_wfid = '0; init_exec = '0;
    salu_wr_wfid = '0;
    salu_wr_exec_en = 1'b0; salu_wr_vcc_en = 1'b0; salu_wr_m0_en = 1'b0; salu_wr_scc_en = 1'b0;
    salu_wr_exec = '0; salu_wr_vcc = '0; salu_wr_m0 = '0; salu_wr_scc = 1'b0;
    valu_vcc_valid = '0;
    alu_rd_en = '0;
  endtask

  task automatic rd_alu(input logic [WFID_W-1:0] w);
    alu_rd_en = 9'h001;
    alu_rd_wfid = '0;
    alu_rd_wfid[WFID_W-1:0] = w;
    tick();
    alu_rd_en = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_rdy;
    rst = 1'b1;
    idle();
    valu_vcc_wfid = '0;
    valu_vcc_data = '0;
    alu_rd_wfid   = '0;
    lsu_rd_wfid   = '0;
    #1;
    chk("rst_alu_exec", alu_rd_exec, 64'd0);
    chk("rst_issue_vcc", 64'(issue_vcc_wr_en), 64'd0);
    chk("rst_err_oor", 64'(err_oor), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Init wfid 5, then read it back on the ALU and LSU ports.
    init_en = 1'b1; init_wfid = 6'd5; init_exec = IEX;
    tick();
    idle();
    chk("init_issue_vcc_en", 64'(issue_vcc_wr_en), 64'd1);
    chk("init_issue_vcc_wfid", 64'(issue_vcc_wr_wfid), 64'd5);
    chk("init_issue_exec_en", 64'(issue_exec_wr_en), 64'd0);
    lsu_rd_wfid = 6'd5;
    rd_alu(6'd5);
    chk("init_rd_exec", alu_rd_exec, IEX);
    chk("init_rd_vcc", alu_rd_vcc, 64'd0);
    chk("init_rd_m0", 64'(alu_rd_m0), 64'd0);
    chk("init_rd_scc", 64'(alu_rd_scc), 64'd0);
    chk("init_lsu_exec", lsu_rd_exec, IEX);
    chk("init_lsu_m0", 64'(lsu_rd_m0), 64'd0);

    // All eight VALU ports request at once; grants go 0..7, one per cycle.
    for (int i = 0; i < NUM_VALU; i++) begin
      valu_vcc_wfid[i*WFID_W +: WFID_W] = 6'(i);
      valu_vcc_data[i*MASK_W +: MASK_W] = TAG | 64'(i);
    end
    valu_vcc_valid = 8'hFF;
    for (int c = 0; c < NUM_VALU; c++) begin
      #1;
      exp_rdy = 8'h01 << c;
      chk("burst_ready", 64'(valu_vcc_ready), 64'(exp_rdy));
      tick();
      valu_vcc_valid[c] = 1'b0;
      chk("burst_issue_en", 64'(issue_vcc_wr_en), 64'd1);
      chk("burst_issue_wfid", 64'(issue_vcc_wr_wfid), 64'(c));
    end
    for (int i = 0; i < NUM_VALU; i++) begin
      rd_alu(6'(i));
      chk("burst_vcc", alu_rd_vcc, TAG | 64'(i));
    end

    // SALU VCC and VALU port 2 target wfid 3 together: SALU wins, port 2 waits one cycle.
    salu_wr_vcc_en = 1'b1; salu_wr_wfid = 6'd3; salu_wr_vcc = VA;
    valu_vcc_wfid[2*WFID_W +: WFID_W] = 6'd3;
    valu_vcc_data[2*MASK_W +: MASK_W] = VB;
    valu_vcc_valid = 8'h04;
    alu_rd_en = 9'h001; alu_rd_wfid = '0; alu_rd_wfid[WFID_W-1:0] = 6'd3;
    #1;
    chk("coll_ready_blocked", 64'(valu_vcc_ready), 64'd0);
    tick();
    salu_wr_vcc_en = 1'b0;
    chk("coll_vcc_salu", alu_rd_vcc, VA);
    chk("coll_issue_wfid", 64'(issue_vcc_wr_wfid), 64'd3);
    #1;
    chk("coll_ready_after", 64'(valu_vcc_ready), 64'h04);
    tick();
    idle();
    chk("coll_vcc_valu", alu_rd_vcc, VB);
    chk("coll_issue_en", 64'(issue_vcc_wr_en), 64'd1);

    // Read wfid 9 on the edge the SALU writes its M0: bypass.
    salu_wr_m0_en = 1'b1; salu_wr_wfid = 6'd9; salu_wr_m0 = 32'h1234;
    alu_rd_en = 9'h001; alu_rd_wfid = '0; alu_rd_wfid[WFID_W-1:0] = 6'd9;
    tick();
    idle();
    chk("byp_m0", 64'(alu_rd_m0), 64'h1234);
    chk("byp_issue_m0", 64'(issue_m0_wr_en), 64'd1);
    chk("byp_issue_exec", 64'(issue_exec_wr_en), 64'd0);
    tick();
    chk("m0_pulse_single", 64'(issue_m0_wr_en), 64'd0);
    chk("rd_hold_m0", 64'(alu_rd_m0), 64'h1234);

    // Several requesters: lowest index (1 -> wfid 5) wins over 2 (wfid 9) and SALU (wfid 3).
    alu_rd_en = 9'h106;
    alu_rd_wfid = '0;
    alu_rd_wfid[1*WFID_W +: WFID_W] = 6'd5;
    alu_rd_wfid[2*WFID_W +: WFID_W] = 6'd9;
    alu_rd_wfid[8*WFID_W +: WFID_W] = 6'd3;
    tick();
    idle();
    chk("sel_low_exec", alu_rd_exec, IEX);
    chk("sel_low_m0", 64'(alu_rd_m0), 64'd0);

    // SALU writes EXEC and SCC of wfid 5 together.
    salu_wr_exec_en = 1'b1; salu_wr_scc_en = 1'b1; salu_wr_wfid = 6'd5;
    salu_wr_exec = 64'h1234_5678; salu_wr_scc = 1'b1;
    tick();
    idle();
    chk("salu_issue_exec", 64'(issue_exec_wr_en), 64'd1);
    chk("salu_issue_scc", 64'(issue_scc_wr_en), 64'd1);
    chk("salu_issue_vcc", 64'(issue_vcc_wr_en), 64'd0);
    rd_alu(6'd5);
    chk("salu_exec", alu_rd_exec, 64'h1234_5678);
    chk("salu_scc", 64'(alu_rd_scc), 64'd1);
    chk("salu_vcc_kept", alu_rd_vcc, TAG | 64'd5);

    // Init and SALU on wfid 7 in one cycle: init wins every field.
    init_en = 1'b1; init_wfid = 6'd7; init_exec = 64'hDEAD;
    salu_wr_exec_en = 1'b1; salu_wr_scc_en = 1'b1; salu_wr_wfid = 6'd7;
    salu_wr_exec = 64'hBEEF; salu_wr_scc = 1'b1;
    tick();
    idle();
    chk("prio_issue_exec", 64'(issue_exec_wr_en), 64'd0);
    chk("prio_issue_scc", 64'(issue_scc_wr_en), 64'd0);
    chk("prio_issue_vcc_wfid", 64'(issue_vcc_wr_wfid), 64'd7);
    rd_alu(6'd7);
    chk("prio_exec", alu_rd_exec, 64'hDEAD);
    chk("prio_vcc", alu_rd_vcc, 64'd0);
    chk("prio_scc", 64'(alu_rd_scc), 64'd0);

    // Out-of-range SALU write, read and VALU request.
    chk("oor_before", 64'(err_oor), 64'd0);
    salu_wr_exec_en = 1'b1; salu_wr_wfid = 6'd45; salu_wr_exec = 64'hFFFF;
    tick();
    idle();
    chk("oor_set", 64'(err_oor), 64'd1);
    chk("oor_issue_exec", 64'(issue_exec_wr_en), 64'd0);
    rd_alu(6'd45);
    chk("oor_rd_zero", alu_rd_exec, 64'd0);
    rd_alu(6'd5);
    chk("oor_no_alias", alu_rd_exec, 64'h1234_5678);
    chk("oor_sticky", 64'(err_oor), 64'd1);
    valu_vcc_wfid[3*WFID_W +: WFID_W] = 6'd50;
    valu_vcc_valid = 8'h08;
    #1;
    chk("oor_valu_drain", 64'(valu_vcc_ready), 64'h08);
    tick();
    idle();
    chk("oor_valu_dropped", 64'(issue_vcc_wr_en), 64'd0);

    // Burst on ports 0,4,5,6 with ptr=4; reset after two grants, then grants restart from port 0.
    for (int i = 0; i < NUM_VALU; i++) begin
      valu_vcc_wfid[i*WFID_W +: WFID_W] = 6'(20 + i);
      valu_vcc_data[i*MASK_W +: MASK_W] = 64'(8'hC0 + i);
    end
    valu_vcc_valid = 8'h71;
    #1;
    chk("rr_first", 64'(valu_vcc_ready), 64'h10);
    tick();
    valu_vcc_valid[4] = 1'b0;
    chk("rr_first_wfid", 64'(issue_vcc_wr_wfid), 64'd24);
    #1;
    chk("rr_second", 64'(valu_vcc_ready), 64'h20);
    tick();
    valu_vcc_valid[5] = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_issue", 64'(issue_vcc_wr_en), 64'd0);
    chk("mid_rst_err", 64'(err_oor), 64'd0);
    chk("mid_rst_alu", alu_rd_exec, 64'd0);
    chk("mid_rst_lsu", lsu_rd_exec, 64'd0);
    chk("mid_rst_ready", 64'(valu_vcc_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", 64'(valu_vcc_ready), 64'h01);
    tick();
    valu_vcc_valid[0] = 1'b0;
    chk("post_rst_wfid20", 64'(issue_vcc_wr_wfid), 64'd20);
    #1;
    chk("post_rst_ready6", 64'(valu_vcc_ready), 64'h40);
    tick();
    idle();
    chk("post_rst_wfid26", 64'(issue_vcc_wr_wfid), 64'd26);
    rd_alu(6'd20);
    chk("post_rst_vcc20", alu_rd_vcc, 64'hC0);
    rd_alu(6'd26);
    chk("post_rst_vcc26", alu_rd_vcc, 64'hC6);
    rd_alu(6'd24);
    chk("post_rst_vcc24", alu_rd_vcc, 64'd0);
    rd_alu(6'd5);
    chk("post_rst_exec5", alu_rd_exec, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
